// File: rtl/sobel_window_generator.sv
// 3x3 neighbourhood generator for the Sobel/Harris edge pipeline.
// Two line buffers plus a shifting 3x3 register array turn a raster pixel stream into windows.
module sobel_window_generator #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int PIX_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sof,
    input  logic                          pixel_valid,
    input  logic [PIX_W-1:0]              pixel_in,
    output logic [PIX_W-1:0]              window [8:0],
    output logic                          window_valid,
    output logic [$clog2(IMG_WIDTH)-1:0]  centre_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] centre_y,
    output logic                          frame_done
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0] COL_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(IMG_HEIGHT - 1);

    logic [XW-1:0]    col_r;
    logic [YW-1:0]    row_r;
    logic [XW-1:0]    col_s;
    logic [YW-1:0]    row_s;
    logic             accept_s;
    logic             restart_s;
    logic             col_last_s;
    logic             row_last_s;
    logic             win_ok_s;
    logic [PIX_W-1:0] lb0_rd_s;
    logic [PIX_W-1:0] lb1_rd_s;

    // lb1 holds line row-1, lb0 holds line row-2; neither is cleared by reset
    logic [PIX_W-1:0] lb0_r [IMG_WIDTH];
    logic [PIX_W-1:0] lb1_r [IMG_WIDTH];

    // Effective position of the pixel being accepted; sof forces it to (0,0)
    always_comb begin
        accept_s  = pixel_valid;
        restart_s = pixel_valid && sof;
        if (restart_s) begin
            col_s = {XW{1'b0}};
            row_s = {YW{1'b0}};
        end else begin
            col_s = col_r;
            row_s = row_r;
        end
        col_last_s = (col_s == COL_LAST);
        row_last_s = (row_s == ROW_LAST);
        win_ok_s   = (row_s >= YW'(2)) && (col_s >= XW'(2));
        lb0_rd_s   = lb0_r[col_s];
        lb1_rd_s   = lb1_r[col_s];
    end

    // Raster position counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r <= {XW{1'b0}};
            row_r <= {YW{1'b0}};
        end else if (accept_s) begin
            if (col_last_s) begin
                col_r <= {XW{1'b0}};
                row_r <= row_last_s ? {YW{1'b0}} : row_s + YW'(1);
            end else begin
                col_r <= col_s + XW'(1);
                row_r <= row_s;
            end
        end
    end

    // Line buffers: asynchronous read gives pre-write data in the accept cycle
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb0_r[col_s] <= lb1_rd_s;
            lb1_r[col_s] <= pixel_in;
        end
    end

    // Window array: shift each row left and load the new column on the right
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) begin
                window[i] <= {PIX_W{1'b0}};
            end
        end else if (accept_s) begin
            window[0] <= window[1];
            window[1] <= window[2];
            window[2] <= lb0_rd_s;
            window[3] <= window[4];
            window[4] <= window[5];
            window[5] <= lb1_rd_s;
            window[6] <= window[7];
            window[7] <= window[8];
            window[8] <= pixel_in;
        end
    end

    // Valid/done pulses and centre coordinates; centre holds between windows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
            centre_x     <= {XW{1'b0}};
            centre_y     <= {YW{1'b0}};
        end else begin
            window_valid <= accept_s && win_ok_s;
            frame_done   <= accept_s && col_last_s && row_last_s;
            if (accept_s && win_ok_s) begin
                centre_x <= col_s - XW'(1);
                centre_y <= row_s - YW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_generator.sv
// Scoreboard bench for sobel_window_generator on a 4x4 image with pixel value base+16*y+x.
module tb_sobel_window_generator;

    localparam int W = 4;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sof = 1'b0;
    logic        pixel_valid = 1'b0;
    logic [15:0] pixel_in = 16'h0000;
    logic [15:0] window [8:0];
    logic        window_valid;
    logic [1:0]  centre_x;
    logic [1:0]  centre_y;
    logic        frame_done;

    typedef struct {
        logic [15:0] w [9];
        int          cx;
        int          cy;
    } exp_t;

    exp_t sb_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_win    = 0;
    int n_fd     = 0;
    int bx = 0;
    int by = 0;
    int base = 0;
    logic drive_last = 1'b0;
    logic last_acc = 1'b0;
    logic acc_last = 1'b0;
    logic rst_prev = 1'b0;
    logic [15:0] prev_w [9];
    logic [1:0]  prev_cx;
    logic [1:0]  prev_cy;

    always #5 clk = ~clk;

    sobel_window_generator #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sof          (sof),
        .pixel_valid  (pixel_valid),
        .pixel_in     (pixel_in),
        .window       (window),
        .window_valid (window_valid),
        .centre_x     (centre_x),
        .centre_y     (centre_y),
        .frame_done   (frame_done)
    );

    // What the DUT saw at each rising edge
    always @(posedge clk) begin
        rst_prev <= rst_n;
        last_acc <= pixel_valid;
        acc_last <= pixel_valid && drive_last;
    end

    // Output monitor: scoreboard pop, gap hold, frame_done, border checks
    initial begin : monitor
        exp_t e;
        int   bad;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && rst_prev === 1'b1) begin
                n_checks++;
                if (frame_done !== acc_last) begin
                    n_fail++;
                    $display("FAIL frame_done: got %b expected %b at %0t", frame_done, acc_last, $time);
                end
                if (frame_done === 1'b1) n_fd++;
                if (window_valid === 1'b1) begin
                    n_checks++;
                    if (last_acc !== 1'b1) begin
                        n_fail++;
                        $display("FAIL valid_in_gap: window_valid=1 after non-accept cycle at %0t", $time);
                    end
                    n_checks++;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_window: got centre (%0d,%0d) expected no window at %0t",
                                 centre_x, centre_y, $time);
                    end else begin
                        e = sb_q.pop_front();
                        bad = -1;
                        for (int i = 0; i < 9; i++) begin
                            if (window[i] !== e.w[i] && bad < 0) bad = i;
                        end
                        if (bad >= 0) begin
                            n_fail++;
                            $display("FAIL window_content: w[%0d] got %h expected %h (centre %0d,%0d)",
                                     bad, window[bad], e.w[bad], e.cx, e.cy);
                        end
                        n_checks++;
                        if (centre_x !== e.cx[1:0] || centre_y !== e.cy[1:0]) begin
                            n_fail++;
                            $display("FAIL centre: got (%0d,%0d) expected (%0d,%0d)",
                                     centre_x, centre_y, e.cx, e.cy);
                        end
                        n_win++;
                    end
                    n_checks++;
                    if (centre_x === 2'd0 || centre_x === 2'd3) begin
                        n_fail++;
                        $display("FAIL centre_x_border: got %0d expected 1 or 2", centre_x);
                    end
                end else if (last_acc === 1'b0) begin
                    n_checks++;
                    bad = -1;
                    for (int i = 0; i < 9; i++) begin
                        if (window[i] !== prev_w[i] && bad < 0) bad = i;
                    end
                    if (bad >= 0 || centre_x !== prev_cx || centre_y !== prev_cy) begin
                        n_fail++;
                        $display("FAIL hold_in_gap: outputs changed without accept (w idx %0d, centre %0d,%0d was %0d,%0d)",
                                 bad, centre_x, centre_y, prev_cx, prev_cy);
                    end
                end
            end
            for (int i = 0; i < 9; i++) prev_w[i] = window[i];
            prev_cx = centre_x;
            prev_cy = centre_y;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic accept(input logic s);
        exp_t e;
        @(posedge clk);
        #1;
        if (s) begin
            bx = 0;
            by = 0;
        end
        sof         = s;
        pixel_valid = 1'b1;
        pixel_in    = 16'(base + 16 * by + bx);
        drive_last  = (bx == W - 1 && by == H - 1);
        if (bx >= 2 && by >= 2) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    e.w[3 * r + c] = 16'(base + 16 * (by - 2 + r) + (bx - 2 + c));
                end
            end
            e.cx = bx - 1;
            e.cy = by - 1;
            sb_q.push_back(e);
        end
        if (bx == W - 1) begin
            bx = 0;
            by = (by == H - 1) ? 0 : by + 1;
        end else begin
            bx++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            pixel_valid = 1'b0;
            sof         = 1'b0;
            drive_last  = 1'b0;
        end
    endtask

    task automatic check_counts(input string name, input int w0, input int f0, input int wexp, input int fexp);
        n_checks++;
        if (n_win - w0 !== wexp || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_windows: got %0d windows (%0d pending) expected %0d", name, n_win - w0, sb_q.size(), wexp);
        end
        n_checks++;
        if (n_fd - f0 !== fexp) begin
            n_fail++;
            $display("FAIL %s_frame_done: got %0d pulses expected %0d", name, n_fd - f0, fexp);
        end
    endtask

    task automatic check_zero(input string name);
        int bad;
        bad = -1;
        for (int i = 0; i < 9; i++) begin
            if (window[i] !== 16'h0000 && bad < 0) bad = i;
        end
        n_checks++;
        if (bad >= 0 || window_valid !== 1'b0 || frame_done !== 1'b0 ||
            centre_x !== 2'd0 || centre_y !== 2'd0) begin
            n_fail++;
            $display("FAIL %s: got valid=%b done=%b centre=(%0d,%0d) w idx %0d nonzero expected all 0",
                     name, window_valid, frame_done, centre_x, centre_y, bad);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        rst_n = 1'b1;
        idle(2);
        check_zero("after_reset_release");
    endtask

    task automatic test_continuous();
        int w0, f0;
        w0 = n_win;
        f0 = n_fd;
        base = 0;
        accept(1'b1);
        for (int i = 1; i < W * H; i++) accept(1'b0);
        idle(4);
        check_counts("continuous", w0, f0, 4, 1);
    endtask

    task automatic test_gaps();
        int w0, f0;
        w0 = n_win;
        f0 = n_fd;
        base = 0;
        for (int i = 0; i < W * H; i++) begin
            while ($urandom_range(0, 1) == 1) idle(1);
            accept(i == 0);
        end
        idle(4);
        check_counts("gaps", w0, f0, 4, 1);
    endtask

    task automatic test_back_to_back();
        int w0, f0;
        w0 = n_win;
        f0 = n_fd;
        base = 0;
        accept(1'b1);
        for (int i = 1; i < W * H; i++) accept(1'b0);
        base = 16'h80;
        accept(1'b1);
        for (int i = 1; i < W * H; i++) accept(1'b0);
        idle(4);
        base = 0;
        check_counts("back_to_back", w0, f0, 8, 2);
    endtask

    task automatic test_sof_resync();
        int w0, f0;
        w0 = n_win;
        f0 = n_fd;
        base = 0;
        accept(1'b1);
        for (int i = 1; i < 5; i++) accept(1'b0);
        accept(1'b1);
        for (int i = 1; i < W * H; i++) accept(1'b0);
        idle(4);
        check_counts("sof_resync", w0, f0, 4, 1);
    endtask

    task automatic test_reset_mid_frame();
        int w0, f0;
        base = 0;
        accept(1'b1);
        for (int i = 1; i < 12; i++) accept(1'b0);
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        pixel_valid = 1'b0;
        sof         = 1'b0;
        drive_last  = 1'b0;
        #1;
        check_zero("reset_mid_frame");
        sb_q.delete();
        bx = 0;
        by = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        w0 = n_win;
        f0 = n_fd;
        for (int i = 0; i < W * H; i++) accept(1'b0);
        idle(4);
        check_counts("after_mid_reset", w0, f0, 4, 1);
    endtask

    initial begin : main
        test_reset();
        test_continuous();
        test_gaps();
        test_back_to_back();
        test_sof_resync();
        test_reset_mid_frame();
        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_window_generator.md
Name: sobel_window_generator

Overview:
- Converts a raster-order RGB565 pixel stream into the 3x3 neighbourhood window that the Sobel/Harris edge pipeline consumes.
- Holds the two previous image lines in on-chip line buffers and a 3x3 register array.
- Emits one window per accepted pixel, once a full neighbourhood exists.
- Sits between the camera/frame-buffer read path and the Sobel filter input.

Parameters:
IMG_WIDTH, 320, pixels per line (≥3)
IMG_HEIGHT, 240, lines per frame (≥3)
PIX_W, 16, pixel width in bits (RGB565)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
sof  input  1  start of frame; qualifies pixel_in as pixel (0,0); ignored unless pixel_valid=1
pixel_valid  input  1  pixel_in accepted this cycle
pixel_in  input  PIX_W  raster-order pixel, left→right, top→bottom
window  output  PIX_W x 9 (unpacked [8:0])  3x3 neighbourhood; index 3*r+c, r=0 oldest line, c=0 oldest column; window[4]=centre, window[8]=newest pixel
window_valid  output  1  window holds a complete neighbourhood, one-cycle pulse per valid window
centre_x  output  clog2(IMG_WIDTH)  x coordinate of window[4]
centre_y  output  clog2(IMG_HEIGHT)  y coordinate of window[4]
frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset (async, rst_n=0): col/row counters=0, window entries=0, window_valid=0, centre_x/centre_y=0, frame_done=0. Line buffer contents are not cleared.
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) give the position of the pixel being accepted.
- Counters advance only when pixel_valid=1. col wraps to 0 and row increments at IMG_WIDTH-1. At (IMG_WIDTH-1, IMG_HEIGHT-1) both wrap to 0.
- sof=1 with pixel_valid=1: the pixel is treated as (0,0) regardless of counter state; counters restart from there. This is the re-sync path for mid-frame sof.
- Line buffers:
  - lb1 holds line row-1; lb0 holds line row-2.
  - Both are IMG_WIDTH deep, read and written at address col.
  - On accept: lb0[col] ← lb1[col]; lb1[col] ← pixel_in.
  - Reads use pre-write values (read-before-write). Inferable as simple dual-port RAM; read data must be available in the same accept cycle, either by registered-address lookahead or LUT RAM.
- Window shift, on accept only:
  - Each row shifts left: c0←c1, c1←c2.
  - New column c2 = {lb0[col], lb1[col], pixel_in} for rows 0, 1, 2.
- window_valid: registered, 1 in the cycle after an accept where row≥2 and col≥2; otherwise 0.
  - Latency from accepting the bottom-right pixel to window_valid = 1 cycle.
  - No border padding: the window never spans a line boundary. (W-2)*(H-2) windows per frame.
- centre_x/centre_y = col-1/row-1 of the accepting pixel, updated with window_valid. They hold their value when window_valid=0.
- pixel_valid=0: all state, window and centre outputs hold; window_valid=0.
- frame_done: registered, 1 in the cycle after the accept at (IMG_WIDTH-1, IMG_HEIGHT-1); may coincide with the final window_valid.
- Next frame: stale line buffer data is never exposed, because window_valid stays suppressed until row≥2 and col≥2 again.
- Reset mid-frame: outputs clear immediately; the next accepted pixel is (0,0) whether or not sof is asserted.

Test Plan:
All tests use IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = 16*y+x.

- Continuous frame, sof on first pixel:
  - First window_valid 1 cycle after pixel (2,2) is accepted (11th pixel).
  - window[0..8] = 0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22; centre=(1,1).
  - Exactly 4 windows with centres (1,1),(2,1),(1,2),(2,2).
  - frame_done pulses once, after pixel 0x33.
- Random pixel_valid gaps (~50% duty): same 4 windows with identical contents; window and centre stable during gaps; window_valid never high in a gap cycle.
- Two back-to-back frames, second with values +0x80:
  - Second frame's first window = 0x80,0x81,0x82,0x90,0x91,0x92,0xA0,0xA1,0xA2.
  - No window_valid during second-frame rows 0–1.
- sof asserted at first-frame pixel (1,1): counters re-sync; the next 11 accepts produce the first window exactly as in the first test.
- rst_n low for 1 cycle after pixel (3,2) of a frame:
  - window_valid, frame_done, window and centre outputs are all 0 during reset.
  - A full frame fed afterwards without sof yields the same 4 windows.
- Line-boundary check: no window ever contains both x=3 and x=0 samples in the same row; assert that centre_x never reaches 0 or 3.
